// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory controller: one 32-bit load/store becomes two half-word
// SRAM transfers, each held for WAIT_CYCLES+1 cycles, with ready low while busy.
module mem_sram_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_BASE    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_res,
  input  logic [31:0] ST_val,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_WE_N
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           wr_q, wr_d;
  logic [16:0]    word_q;
  logic [31:0]    data_q;
  logic [31:0]    rdata_q;
  logic [31:0]    offset;
  logic           unused_addr_bits;
  logic           req, last, strobe, hi, take;

  assign req    = MEM_R_EN | MEM_W_EN;
  assign offset = ALU_res - 32'(MEM_BASE);
  assign unused_addr_bits = ^{offset[31:19], offset[1:0]};
  assign last   = (cnt_q == LAST);
  // With no wait states the single phase cycle must still carry the strobe.
  assign strobe = (WAIT_CYCLES == 0) || !last;
  assign hi     = (state_q == HI);
  assign rdata  = rdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    take        = 1'b0;
    ready       = 1'b1;
    SRAM_ADDR   = '0;
    SRAM_DQ_out = '0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    case (state_q)
      IDLE: begin
        if (req) begin
          ready   = 1'b0;
          take    = 1'b1;
          wr_d    = MEM_W_EN;
          cnt_d   = '0;
          state_d = LO;
        end
      end
      LO, HI: begin
        ready     = 1'b0;
        SRAM_ADDR = {word_q, hi};
        if (wr_q) begin
          SRAM_DQ_oe  = 1'b1;
          SRAM_DQ_out = hi ? data_q[31:16] : data_q[15:0];
          SRAM_WE_N   = ~strobe;
        end
        if (last) begin
          cnt_d   = '0;
          state_d = hi ? DONE : HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      // Read data is captured on the edge that closes each phase.
      if (state_q == LO && last && !wr_q) rdata_q[15:0]  <= SRAM_DQ_in;
      if (state_q == HI && last && !wr_q) rdata_q[31:16] <= SRAM_DQ_in;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      word_q <= offset[18:2];
      data_q <= ST_val;
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: word-level reference memory, half-word SRAM models,
// one instance with WAIT_CYCLES=1 and one with WAIT_CYCLES=0.
module tb_mem_sram_ctrl;

  localparam int W1   = 1;
  localparam int BASE = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ren1, wen1, ready1, oe1, we_n1;
  logic [31:0] alu1, st1, rdata1;
  logic [17:0] addr1;
  logic [15:0] dqo1, dqi1;

  logic        ren0, wen0, ready0, oe0, we_n0;
  logic [31:0] alu0, st0, rdata0;
  logic [17:0] addr0;
  logic [15:0] dqo0, dqi0;

  logic [15:0] sram1 [0:262143];
  logic [15:0] sram0 [0:262143];
  logic [31:0] ref_mem [0:131071];

  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] exp_rdata;
  logic [17:0] g_alo, g_ahi;

  mem_sram_ctrl #(.WAIT_CYCLES(W1), .MEM_BASE(BASE)) dut1 (
    .clk(clk), .rst(rst), .MEM_R_EN(ren1), .MEM_W_EN(wen1), .ALU_res(alu1),
    .ST_val(st1), .rdata(rdata1), .ready(ready1), .SRAM_ADDR(addr1),
    .SRAM_DQ_out(dqo1), .SRAM_DQ_oe(oe1), .SRAM_DQ_in(dqi1), .SRAM_WE_N(we_n1));

  mem_sram_ctrl #(.WAIT_CYCLES(0), .MEM_BASE(BASE)) dut0 (
    .clk(clk), .rst(rst), .MEM_R_EN(ren0), .MEM_W_EN(wen0), .ALU_res(alu0),
    .ST_val(st0), .rdata(rdata0), .ready(ready0), .SRAM_ADDR(addr0),
    .SRAM_DQ_out(dqo0), .SRAM_DQ_oe(oe0), .SRAM_DQ_in(dqi0), .SRAM_WE_N(we_n0));

  // Asynchronous-read, strobe-written SRAM models
  assign dqi1 = sram1[addr1];
  assign dqi0 = sram0[addr0];
  always @(posedge clk) begin
    if (!we_n1) sram1[addr1] <= dqo1;
    if (!we_n0) sram0[addr0] <= dqo0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return 17'(off / 4);
  endfunction

  // Called at a falling edge with the controller idle; returns at a falling edge, idle again.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    int lowc = 0, wec = 0, oec = 0, oebad = 0;
    bit done = 0;
    logic [16:0] wd;
    wd = word_of(a);
    ren1 = rd; wen1 = wr; alu1 = a; st1 = d;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (k > 0 && ready1) begin
        done = 1;
        break;
      end
      if (!ready1) lowc++;
      if (!we_n1) begin
        wec++;
        if (!oe1) oebad++;
      end
      if (oe1) oec++;
      if (k == 1) g_alo = addr1;
      if (k == W1 + 2) g_ahi = addr1;
      @(posedge clk);
      #1;
      if (k == 0) begin
        ren1 = 0; wen1 = 0; alu1 = $urandom; st1 = $urandom;
      end
      @(negedge clk);
    end
    if (!done) chk($sformatf("%s.timeout", tag), 32'd0, 32'd1);
    if (wr) ref_mem[wd] = d;
    else    exp_rdata   = ref_mem[wd];
    chk($sformatf("%s.rdata", tag), rdata1, exp_rdata);
    chk($sformatf("%s.busy", tag), lowc, 2 * W1 + 3);
    chk($sformatf("%s.we_cycles", tag), wec, wr ? 2 * W1 : 0);
    chk($sformatf("%s.oe_cycles", tag), oec, wr ? 2 * (W1 + 1) : 0);
    chk($sformatf("%s.we_wo_oe", tag), oebad, 0);
    chk($sformatf("%s.addr_lo", tag), g_alo, {wd, 1'b0});
    chk($sformatf("%s.addr_hi", tag), g_ahi, {wd, 1'b1});
    if (wr) begin
      chk($sformatf("%s.sram_lo", tag), sram1[{wd, 1'b0}], d[15:0]);
      chk($sformatf("%s.sram_hi", tag), sram1[{wd, 1'b1}], d[31:16]);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    logic [15:0] lo_before, hi_before;
    logic [31:0] a0, a1;
    logic [7:0]  pat;
    int          wec0;

    rst = 1;
    ren1 = 0; wen1 = 0; alu1 = 0; st1 = 0;
    ren0 = 0; wen0 = 0; alu0 = 0; st0 = 0;
    exp_rdata = 0;
    for (int i = 0; i < 131072; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      sram1[2*i] = v[15:0]; sram1[2*i+1] = v[31:16];
      sram0[2*i] = v[15:0]; sram0[2*i+1] = v[31:16];
    end
    #1;
    chk("reset.rdata", rdata1, 32'd0);
    chk("reset.we_n", we_n1, 1);
    chk("reset.oe", oe1, 0);
    chk("reset.addr", addr1, 0);
    chk("reset.dq_out", dqo1, 0);
    chk("reset.ready", ready1, 1);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);

    access(0, 1, 1024, 32'hDEADBEEF, "st_deadbeef");
    chk("sram0_beef", sram1[0], 16'hBEEF);
    chk("sram1_dead", sram1[1], 16'hDEAD);
    access(1, 0, 1024, 0, "ld_deadbeef");
    chk("rdata_deadbeef", rdata1, 32'hDEADBEEF);
    access(1, 0, 1036, 0, "ld1036");
    chk("a1036_lo", g_alo, 6);
    chk("a1036_hi", g_ahi, 7);
    access(1, 0, 1037, 0, "ld1037");
    chk("a1037_lo", g_alo, 6);
    chk("a1037_hi", g_ahi, 7);
    access(1, 0, 1020, 0, "ld1020");
    chk("a1020_lo", g_alo, 18'h3FFFE);
    chk("a1020_hi", g_ahi, 18'h3FFFF);
    access(1, 1, 1100, 32'h12345678, "both_en");
    access(1, 0, 1100, 0, "ld_both");
    chk("both_val", rdata1, 32'h12345678);

    // Reset in the middle of a store's low phase
    lo_before = sram1[0];
    hi_before = sram1[1];
    wen1 = 1; alu1 = 1024; st1 = $urandom;
    @(posedge clk);
    #1;
    wen1 = 0;
    chk("rst.pre_we", we_n1, 0);
    #2 rst = 1;
    #1;
    chk("rst.we_n", we_n1, 1);
    chk("rst.oe", oe1, 0);
    chk("rst.ready", ready1, 1);
    chk("rst.addr", addr1, 0);
    chk("rst.rdata", rdata1, 0);
    exp_rdata = 0;
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("rst.sram_hi", sram1[1], hi_before);
    chk("rst.sram_lo", sram1[0], lo_before);
    access(1, 0, 1024, 0, "post_rst");

    for (int i = 0; i < 24; i++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a  = 32'(BASE - 64) + 32'($urandom_range(0, 255));
      access(op != 1, op >= 1, a, $urandom, $sformatf("rnd%0d", i));
    end

    // Zero wait states: two loads back to back with the enable held
    a0 = 32'(BASE) + 4 * (1000 + $urandom_range(0, 999));
    a1 = 32'(BASE) + 4 * (1000 + $urandom_range(0, 999)) + 32'($urandom_range(0, 3));
    wec0 = 0;
    pat  = '0;
    ren0 = 1; alu0 = a0;
    for (int k = 0; k < 8; k++) begin
      #1;
      pat[7-k] = ready0;
      if (!we_n0) wec0++;
      if (k == 3) begin
        chk("w0.rdata0", rdata0, ref_mem[word_of(a0)]);
        alu0 = a1;
      end
      if (k == 7) begin
        chk("w0.rdata1", rdata0, ref_mem[word_of(a1)]);
        ren0 = 0;
      end
      @(negedge clk);
    end
    chk("w0.ready_pattern", pat, 8'b0001_0001);
    chk("w0.we_n_low", wec0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
